// File: rtl/data_ram_pkg.sv
// ============================================================================
// data_ram_pkg : shared types and constants for the data_ram block.  Rev 1.0
// ============================================================================
`default_nettype none

package data_ram_pkg;

  typedef enum logic [0:0] {
    DRAM_CLEAR = 1'b0,
    DRAM_READY = 1'b1
  } dram_state_t;

  localparam int                   ERR_CNT_W   = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;
  localparam int                   NUM_LANES   = 4;

  // Saturating increment for the out-of-range access counter.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_clear_seq.sv
// ============================================================================
// data_ram_clear_seq : post-reset sweep zeroing every word, holds busy meanwhile.
// Rev 1.0
// ============================================================================
`default_nettype none

module data_ram_clear_seq
  import data_ram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  dram_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DRAM_CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else if (state == DRAM_CLEAR) begin
      // The last index is written on this edge; busy drops together with it.
      if (clr_idx == LAST_IDX) begin
        state <= DRAM_READY;
        busy  <= 1'b0;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  assign clr_we = busy;

endmodule

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// data_ram : byte-enabled data memory with range check and error counter;
//            optional post-reset clear under DATA_RAM_CLEAR_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ram_r_addr,
  output logic [31:0] ram_r_data,
  input  logic [31:0] ram_w_addr,
  input  logic [3:0]  ram_wen,
  input  logic [31:0] ram_w_data,
  output logic        ram_busy,
  output logic        ram_err,
  output logic [15:0] err_cnt
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic          r_oor;
  logic          w_oor;
  logic          w_ok;
  logic          err_hit;
  logic          unused_addr_bits;

  assign r_idx = ram_r_addr[AW+1:2];
  assign w_idx = ram_w_addr[AW+1:2];
  assign r_oor = |ram_r_addr[31:AW+2];
  assign w_oor = |ram_w_addr[31:AW+2];
  assign w_ok  = !w_oor && !ram_busy;

  assign unused_addr_bits = ^{ram_r_addr[1:0], ram_w_addr[1:0]};

  // No forwarding: a same-cycle write lands after this read is taken.
  assign ram_r_data = (r_oor || ram_busy) ? 32'h0 : mem[r_idx];

`ifdef DATA_RAM_CLEAR_EN
  logic          clr_we;
  logic [AW-1:0] clr_idx;

  data_ram_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .busy    (ram_busy)
  );

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= 32'h0;
    end else if (w_ok) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        if (ram_wen[n]) mem[w_idx][8*n +: 8] <= ram_w_data[8*n +: 8];
      end
    end
  end
`else
  assign ram_busy = 1'b0;

  always_ff @(posedge clk) begin
    if (w_ok) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        if (ram_wen[n]) mem[w_idx][8*n +: 8] <= ram_w_data[8*n +: 8];
      end
    end
  end
`endif

  // A read and a write both out of range in one cycle count as one event.
  assign err_hit = r_oor || (w_oor && (ram_wen != 4'b0000));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      ram_err <= err_hit;
      if (err_hit) err_cnt <= err_cnt_inc(err_cnt);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_ram.sv
// ============================================================================
// tb_data_ram : randomized + directed bench for data_ram against a word-array model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_ram;

  localparam int DEPTH = 16;
`ifdef DATA_RAM_CLEAR_EN
  localparam int CLR_LEN = DEPTH;
`else
  localparam int CLR_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ram_r_addr = '0;
  logic [31:0] ram_r_data;
  logic [31:0] ram_w_addr = '0;
  logic [3:0]  ram_wen = '0;
  logic [31:0] ram_w_data = '0;
  logic        ram_busy;
  logic        ram_err;
  logic [15:0] err_cnt;

  data_ram #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data),
    .ram_w_addr (ram_w_addr),
    .ram_wen    (ram_wen),
    .ram_w_data (ram_w_data),
    .ram_busy   (ram_busy),
    .ram_err    (ram_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [31:0] mem_m   [DEPTH];
  logic [3:0]  known_m [DEPTH];
  int          clr_left;
  logic        err_m;
  int          cnt_m;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    chk("busy", {31'h0, ram_busy}, {31'h0, clr_left > 0});
    chk("err", {31'h0, ram_err}, {31'h0, err_m});
    chk("err_cnt", {16'h0, err_cnt}, cnt_m);
  endtask

  // Called at posedge+1; drives one cycle, checks read data, then post-edge state.
  task automatic step(input logic [31:0] ra, input logic [31:0] wa,
                      input logic [3:0] wen, input logic [31:0] wd);
    bit          r_oor, w_oor, busy_pre;
    int unsigned ri, wi;
    ram_r_addr = ra;
    ram_w_addr = wa;
    ram_wen    = wen;
    ram_w_data = wd;
    #3;
    r_oor    = (ra >> 2) >= DEPTH;
    w_oor    = (wa >> 2) >= DEPTH;
    ri       = (ra >> 2) % DEPTH;
    wi       = (wa >> 2) % DEPTH;
    busy_pre = clr_left > 0;
    if (r_oor || busy_pre) chk("rdata_zero", ram_r_data, 32'h0);
    else if (known_m[ri] == 4'hF) chk("rdata", ram_r_data, mem_m[ri]);
    if (!busy_pre && !w_oor) begin
      for (int n = 0; n < 4; n++) begin
        if (wen[n]) begin
          mem_m[wi][8*n +: 8] = wd[8*n +: 8];
          known_m[wi][n] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_m[i] = 32'h0;
          known_m[i] = 4'hF;
        end
      end
    end
    err_m = r_oor || (w_oor && wen != 4'h0);
    if (err_m && cnt_m < 32'hFFFF) cnt_m++;
    chk_outs();
  endtask

  task automatic apply_reset(input int hold);
    rst_n    = 1'b0;
    clr_left = CLR_LEN;
    err_m    = 1'b0;
    cnt_m    = 0;
    #1;
    chk_outs();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a = a % (DEPTH * 4);
    else if (a < DEPTH * 4) a = a + DEPTH * 4;
    return a;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = 32'h0;
      known_m[i] = 4'h0;
    end
    @(posedge clk);
    #1;
    apply_reset(2);

`ifdef DATA_RAM_CLEAR_EN
    // Clear window: writes attempted throughout must be dropped.
    n = 0;
    while (ram_busy && n < 100) begin
      step(32'h0, 32'h4, 4'hF, $urandom);
      n++;
    end
    chk("busy_cycles", n, DEPTH);
    step(32'h3C, 32'h0, 4'h0, 32'h0);
    chk("clear_read_3c", ram_r_data, 32'h0);
    step(32'h4, 32'h0, 4'h0, 32'h0);
    chk("clear_drop_4", ram_r_data, 32'h0);
`else
    chk("busy_const", {31'h0, ram_busy}, 32'h0);
    for (int i = 0; i < DEPTH; i++) step(32'h0, i * 4, 4'hF, $urandom);
`endif

    // Lane merge
    step(32'h0, 32'h10, 4'b1111, 32'hDEADBEEF);
    step(32'h0, 32'h10, 4'b0100, 32'h00AA0000);
    step(32'h10, 32'h0, 4'b0000, 32'h0);
    chk("lane_merge", ram_r_data, 32'hDEAABEEF);

    // Same-cycle read/write: old data this cycle, new data next cycle
    step(32'h0, 32'h4, 4'hF, 32'h11223344);
    ram_r_addr = 32'h4;
    ram_w_addr = 32'h4;
    ram_wen    = 4'b1000;
    ram_w_data = 32'h12000000;
    #3;
    chk("rw_same_old", ram_r_data, 32'h11223344);
    step(32'h4, 32'h4, 4'b1000, 32'h12000000);
    step(32'h4, 32'h0, 4'h0, 32'h0);
    chk("rw_same_new", ram_r_data, 32'h12223344);

    // Out-of-range write
    step(32'h0, 32'h40, 4'b0001, 32'h000000FF);
    chk("oor_err_pulse", {31'h0, ram_err}, 32'h1);
    chk("oor_err_cnt", {16'h0, err_cnt}, 32'h1);
    step(32'h40, 32'h0, 4'h0, 32'h0);
    step(32'h0, 32'h0, 4'h0, 32'h0);
    chk("oor_err_drop", {31'h0, ram_err}, 32'h0);
    chk("oor_array_0", ram_r_data, mem_m[0]);

    // Reset, then reset again mid-clear
    apply_reset(1);
`ifdef DATA_RAM_CLEAR_EN
    for (int i = 0; i < 7; i++) step(32'h0, 32'h8, 4'hF, $urandom);
    apply_reset(1);
    n = 0;
    while (ram_busy && n < 100) begin
      step(32'h0, 32'h10, 4'hF, $urandom);
      n++;
    end
    chk("busy_cycles_restart", n, DEPTH);
    step(32'h10, 32'h0, 4'h0, 32'h0);
    chk("restart_read_10", ram_r_data, 32'h0);
`else
    step(32'h10, 32'h0, 4'h0, 32'h0);
    chk("retain_after_reset", ram_r_data, 32'hDEAABEEF);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(rand_addr(), rand_addr(), 4'($urandom_range(0, 15)), $urandom);
    end

    // Saturation of the error counter
    for (int i = 0; i < 65540; i++) step(32'hFFFF_FFF0, 32'h0, 4'h0, 32'h0);
    chk("sat_cnt", {16'h0, err_cnt}, 32'hFFFF);
    chk("sat_err", {31'h0, ram_err}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
